// File: rtl/dac_pacer_pkg.sv
// dac_pacer_pkg: shared defaults and FSM state type for the DAC sample pacer
package dac_pacer_pkg;
    localparam int         DAC_W_DEF      = 10;
    localparam logic [9:0] RESET_CODE_DEF = 10'h200;
    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_e;
endpackage

// File: rtl/dac_sample_fifo.sv
// dac_sample_fifo: synchronous FIFO with exact occupancy count
//   clk_i, rst_ni      : clock, async active-low reset
//   push_i, data_i     : write request/data (ignored while full, even if popping)
//   pop_i, data_o      : read request, head of queue (no write-to-read bypass)
//   full_o, empty_o    : status
//   level_o            : occupancy 0..DEPTH
module dac_sample_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          push_ok, pop_ok;
    // pointers carry an extra wrap bit so the difference is the exact level
    assign level_o = wr_q - rd_q;
    assign full_o  = level_o == LW'(DEPTH);
    assign empty_o = wr_q == rd_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + LW'(push_ok);
            rd_q <= rd_q + LW'(pop_ok);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer: buffers core samples and releases them to the DAC at a fixed rate
//   clk_i, rst_ni          : PLL clock, async active-low reset
//   in_data_i/in_valid_i   : sample from core; in_ready_o = FIFO not full
//   enable_i               : playback enable
//   div_i                  : sample period in clocks (0 behaves as 1)
//   clear_flags_i          : clears underflow_sticky_o (a same-cycle underflow wins)
//   dac_code_o             : registered DAC code
//   sample_strobe_o        : one-cycle pulse when dac_code_o takes a new sample
//   fifo_level_o           : FIFO occupancy
//   underflow_sticky_o     : set when a sample was due but the FIFO was empty
module dac_sample_pacer
    import dac_pacer_pkg::*;
#(
    parameter int               DAC_W       = DAC_W_DEF,
    parameter int               DEPTH       = 8,
    parameter int               PRIME_LEVEL = 4,
    parameter int               DIV_W       = 16,
    parameter logic [DAC_W-1:0] RESET_CODE  = DAC_W'(RESET_CODE_DEF)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DAC_W-1:0]        in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    enable_i,
    input  logic [DIV_W-1:0]        div_i,
    input  logic                    clear_flags_i,
    output logic [DAC_W-1:0]        dac_code_o,
    output logic                    sample_strobe_o,
    output logic [$clog2(DEPTH):0]  fifo_level_o,
    output logic                    underflow_sticky_o
);
    localparam int LW = $clog2(DEPTH) + 1;
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_eff;
    logic [DAC_W-1:0] dac_q, dac_d, head;
    logic             strobe_q, strobe_d, uf_q, uf_d;
    logic             pop, full, empty, tick;
    dac_sample_fifo #(.W(DAC_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (in_valid_i),
        .data_i  (in_data_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level_o)
    );
    assign in_ready_o         = !full;
    assign dac_code_o         = dac_q;
    assign sample_strobe_o    = strobe_q;
    assign underflow_sticky_o = uf_q;
    assign div_eff            = (div_i == '0) ? DIV_W'(1) : div_i;
    // period compared against div captured at RUN entry / last wrap
    assign tick               = (state_q == ST_RUN) && (cnt_q == div_q - 1'b1);
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        dac_d    = dac_q;
        strobe_d = 1'b0;
        uf_d     = uf_q && !clear_flags_i;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: state_d = enable_i ? ST_PRIME : ST_IDLE;
            ST_PRIME: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (fifo_level_o >= LW'(PRIME_LEVEL)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    div_d   = div_eff;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    cnt_d = '0;
                    div_d = div_eff;
                    if (!empty) begin
                        pop      = 1'b1;
                        dac_d    = head;
                        strobe_d = 1'b1;
                    end else begin
                        uf_d    = 1'b1;
                        state_d = ST_PRIME;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_W'(1);
            dac_q    <= RESET_CODE;
            strobe_q <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            dac_q    <= dac_d;
            strobe_q <= strobe_d;
            uf_q     <= uf_d;
        end
    end
endmodule

// File: tb/tb_dac_sample_pacer.sv
// tb_dac_sample_pacer: scoreboard bench for dac_sample_pacer
module tb_dac_sample_pacer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [9:0]  in_data = '0;
    logic        in_valid = 1'b0, enable = 1'b0, clear_flags = 1'b0;
    logic [15:0] div = 16'd4;
    logic        in_ready, strobe, sticky;
    logic [9:0]  code;
    logic [3:0]  level;
    int          checks = 0, fails = 0, cyc = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  last_code = 10'h200;

    dac_sample_pacer dut (
        .clk_i(clk), .rst_ni(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .enable_i(enable), .div_i(div), .clear_flags_i(clear_flags),
        .dac_code_o(code), .sample_strobe_o(strobe), .fifo_level_o(level),
        .underflow_sticky_o(sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s: no DUT response within bound (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: accepted samples queue up in order, each strobe must present the
    // oldest one, the code must hold between strobes, and level tracks queue size.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_code = 10'h200;
        end else begin
            if (strobe) begin
                if (exp_q.size() == 0) timeout("strobe_without_sample");
                else chk("code_order", code, exp_q.pop_front());
                last_code = code;
            end else begin
                chk("code_hold", code, last_code);
            end
            chk("level", level, exp_q.size());
            chk("in_ready", in_ready, exp_q.size() < 8);
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        enable = 1'b0;
        clear_flags = 1'b0;
        @(negedge clk);
        chk("rst_code", code, 10'h200);
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_strobe", strobe, 0);
        chk("rst_sticky", sticky, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push(input logic [9:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data = v;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) timeout("push");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_strobe(output int t);
        int n = 0;
        @(negedge clk);
        while (!strobe && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!strobe) timeout("strobe_wait");
        t = cyc;
    endtask

    initial begin
        int t, t2, t_en, lv;
        do_reset();
        // steady play at div=4
        div = 16'd4;
        for (int i = 1; i <= 8; i++) push(10'(i));
        @(negedge clk);
        chk("t2_level_full", level, 8);
        @(posedge clk);
        #1 enable = 1'b1;
        t_en = cyc;
        wait_strobe(t);
        chk("t2_first_latency", t - t_en, 6);
        chk("t2_first_code", code, 1);
        for (int k = 2; k <= 8; k++) begin
            wait_strobe(t2);
            chk("t2_period", t2 - t, 4);
            chk("t2_code", code, k);
            t = t2;
        end
        repeat (4) @(negedge clk);
        chk("t2_underflow_sticky", sticky, 1);
        chk("t2_underflow_hold", code, 8);
        // underflow and re-prime at div=2
        do_reset();
        div = 16'd2;
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) push(10'(i));
        wait_strobe(t);
        for (int k = 2; k <= 4; k++) begin
            wait_strobe(t2);
            chk("t3_period", t2 - t, 2);
            t = t2;
        end
        repeat (2) @(negedge clk);
        chk("t3_sticky", sticky, 1);
        chk("t3_hold", code, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_no_strobe", strobe, 0);
        end
        @(posedge clk);
        #1;
        for (int i = 5; i <= 8; i++) push(10'(i));
        wait_strobe(t);
        chk("t3_resume_code", code, 5);
        chk("t3_sticky_held", sticky, 1);
        @(posedge clk);
        #1 clear_flags = 1'b1;
        @(posedge clk);
        #1 clear_flags = 1'b0;
        @(negedge clk);
        chk("t3_cleared", sticky, 0);
        wait_strobe(t);
        wait_strobe(t);
        chk("t3_last_code", code, 8);
        @(posedge clk);
        #1 clear_flags = 1'b1;
        @(posedge clk);
        #1 clear_flags = 1'b0;
        @(negedge clk);
        chk("t3_set_wins", sticky, 1);
        // full FIFO, push+pop at full
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 10'h10 + 10'(i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t4_level", level, 8);
        chk("t4_in_ready", in_ready, 0);
        @(posedge clk);
        #1 in_data = 10'h3ff;
        div = 16'd1;
        enable = 1'b1;
        wait_strobe(t);
        chk("t4_pushpop_full", level, 7);
        chk("t4_code", code, 10'h10);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 enable = 1'b0;
        // div=0 and div=1 both play one sample per clock
        for (int dv = 0; dv < 2; dv++) begin
            do_reset();
            div = 16'(dv);
            for (int i = 0; i < 6; i++) push(10'h40 + 10'(i));
            enable = 1'b1;
            wait_strobe(t);
            for (int k = 0; k < 5; k++) begin
                wait_strobe(t2);
                chk("t5_fast_period", t2 - t, 1);
                t = t2;
            end
        end
        // div change mid-run lands on the following wrap
        do_reset();
        div = 16'd3;
        for (int i = 0; i < 8; i++) push(10'h80 + 10'(i));
        enable = 1'b1;
        wait_strobe(t);
        wait_strobe(t2);
        chk("t5_div3", t2 - t, 3);
        @(posedge clk);
        #1 div = 16'd5;
        t = t2;
        wait_strobe(t2);
        chk("t5_div_current_wrap", t2 - t, 3);
        t = t2;
        wait_strobe(t2);
        chk("t5_div5", t2 - t, 5);
        t = t2;
        wait_strobe(t2);
        chk("t5_div5b", t2 - t, 5);
        // enable drop on a tick cycle
        do_reset();
        div = 16'd4;
        for (int i = 0; i < 8; i++) push(10'h100 + 10'(i));
        enable = 1'b1;
        wait_strobe(t);
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        lv = int'(level);
        @(negedge clk);
        chk("t6_no_pop", strobe, 0);
        chk("t6_level", level, lv);
        chk("t6_code", code, 10'h100);
        repeat (6) begin
            @(negedge clk);
            chk("t6_idle_quiet", strobe, 0);
        end
        @(posedge clk);
        #1 enable = 1'b1;
        t_en = cyc;
        wait_strobe(t);
        chk("t6_restart_latency", t - t_en, 6);
        chk("t6_restart_code", code, 10'h101);
        // random traffic, then a reset mid-stream
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_valid = $urandom_range(0, 99) < 55;
            in_data = 10'($urandom);
            clear_flags = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 39) == 0) enable = !enable;
            if ($urandom_range(0, 29) == 0) div = 16'($urandom_range(0, 4));
            @(posedge clk);
            #1;
        end
        do_reset();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
